rpa_shift_mult: RTL and testbench



---
 rtl/rpa_shift_mult.sv | 143 ++++++++++++++
 tb/tb_rpa_shift_mult.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rpa_shift_mult.sv
// rpa_shift_mult: sequential unsigned shift-and-add multiplier.
// Each RUN cycle performs one conditional accumulate through a Peres-gate
// reversible ripple-carry adder (RPA_peres) sized to 2*BITS.
// Optional feature macro: RPA_MULT_EARLY_EXIT_EN. When it is defined, RUN stops
// as soon as the remaining multiplier bits are all zero, and b == 0 skips RUN
// entirely. The product value is the same in both builds.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready)
// RUN   | one shift/conditional-add step per clock (busy)
// DONE  | product held until the consumer takes it (out_valid)

module RPA_peres #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;

   assign c[0] = cin;

   // Two cascaded Peres gates per bit: (a,b,0) gives p=a^b, g=a&b;
   // (p,c,g) gives sum=p^c and carry=(p&c)^g.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign p[i]   = a[i] ^ b[i];
      assign g[i]   = a[i] & b[i];
      assign sum[i] = p[i] ^ c[i];
      assign c[i+1] = (p[i] & c[i]) ^ g[i];
   end

   assign cout = c[WIDTH];
endmodule

module rpa_shift_mult #(
   parameter int BITS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BITS-1:0]   a,
   input  logic [BITS-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*BITS-1:0] product,
   output logic              busy
);
   localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2*BITS-1:0] md;
   logic [2*BITS-1:0] acc;
   logic [2*BITS-1:0] sum;
   logic [BITS-1:0]   mr;
   logic [CW-1:0]     cnt;
   logic              unused_cout;
   logic              accept;
   logic              last_step;

   // The product always fits in 2*BITS, so the carry out is never set.
   RPA_peres #(.WIDTH(2*BITS)) u_add (
      .a    (acc),
      .b    (md),
      .cin  (1'b0),
      .sum  (sum),
      .cout (unused_cout)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);
   assign product   = acc;
   assign accept    = in_valid && in_ready;

`ifdef RPA_MULT_EARLY_EXIT_EN
   assign last_step = (cnt == LAST) || ((mr >> 1) == '0);
`else
   assign last_step = (cnt == LAST);
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef RPA_MULT_EARLY_EXIT_EN
               state_nxt = (b == '0) ? DONE : RUN;
`else
               state_nxt = RUN;
`endif
            end
         end
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand load on accept, then one shift/conditional-add per RUN cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md  <= '0;
         mr  <= '0;
         acc <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  md  <= {{BITS{1'b0}}, a};
                  mr  <= b;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (mr[0]) acc <= sum;
               md  <= md << 1;
               mr  <= mr >> 1;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rpa_shift_mult.sv
// Directed bench for rpa_shift_mult at BITS = 4. Expected latencies follow the
// build: with RPA_MULT_EARLY_EXIT_EN defined they depend on b's top set bit.

module tb_rpa_shift_mult;
   localparam int BITS = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] a;
   logic [BITS-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [7:0]      product;
   logic            busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cout_hits = 0;

   rpa_shift_mult #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Adder carry-out must stay low on every RUN cycle.
   always @(negedge clk) begin
      if (busy && dut.unused_cout !== 1'b0) cout_hits++;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, want done");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   function automatic int exp_lat(input logic [BITS-1:0] bv);
`ifdef RPA_MULT_EARLY_EXIT_EN
      int l;
      l = 0;
      for (int i = 0; i < BITS; i++) if (bv[i]) l = i + 1;
      return l;
`else
      return BITS;
`endif
   endfunction

   // Accept one operand pair, measure latency, optionally hold off the
   // consumer for 'hold' cycles (pulsing in_valid meanwhile), then hand off.
   task automatic run_op(input string tag, input logic [BITS-1:0] av,
                         input logic [BITS-1:0] bv, input int hold,
                         input int exp_prod);
      int lat;
      int wait_n;
      wait_n = 0;
      while (!in_ready && wait_n < 20) begin
         @(posedge clk); #1; wait_n++;
      end
      check({tag, "_ready_before"}, int'(in_ready), 1);
      @(negedge clk);
      a = av; b = bv; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = '0; b = '0;
      check({tag, "_ready_after_accept"}, int'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_latency"}, lat, exp_lat(bv));
      check({tag, "_product"}, int'(product), exp_prod);
      for (int i = 0; i < hold; i++) begin
         a = 4'hF; b = 4'hF; in_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, int'(out_valid), 1);
         check({tag, "_hold_ready"}, int'(in_ready), 0);
         check({tag, "_hold_product"}, int'(product), exp_prod);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_valid_after_hs"}, int'(out_valid), 0);
      check({tag, "_ready_after_hs"}, int'(in_ready), 1);
      check({tag, "_busy_after_hs"}, int'(busy), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_product", int'(product), 8'h00);
      @(negedge clk); rst_n = 1'b1;

      run_op("m13x11", 4'd13, 4'd11, 0, 8'h8F);
      run_op("m15x15", 4'd15, 4'd15, 0, 8'hE1);
      run_op("m7x6_bp", 4'd7, 4'd6, 5, 8'h2A);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      a = 4'd9; b = 4'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("midrst_busy", int'(busy), 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_busy_low", int'(busy), 0);
      check("midrst_acc", int'(product), 0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
         end
         check("midrst_no_valid", seen, 0);
      end
      run_op("m3x5", 4'd3, 4'd5, 0, 8'h0F);

      run_op("m9x0", 4'd9, 4'd0, 0, 8'h00);
      run_op("m5x1", 4'd5, 4'd1, 0, 8'h05);
      run_op("m3x8", 4'd3, 4'd8, 0, 8'h18);
      run_op("m6x3_bp", 4'd6, 4'd3, 2, 8'h12);

      check("cout_never_set", cout_hits, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
